// File: rtl/cpu_reg_bank.sv
// cpu_reg_bank: small register file with one write port and one registered
// read port. It can also copy one register to another (two busy cycles) and
// clear every register in sequence (DEPTH busy cycles). A read sees a write
// made to the same register on the same edge.
module cpu_reg_bank #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             set,
    input  logic [AW-1:0]    wr_sel,
    input  logic             enable,
    input  logic [AW-1:0]    rd_sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             mv_req,
    input  logic [AW-1:0]    mv_src,
    input  logic [AW-1:0]    mv_dst,
    input  logic             clr_req,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MV_RD = 2'd1,
        MV_WR = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             busy_q;

    // single write port shared by IDLE writes, move writes and clear writes
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

    // next-state logic and write-port selection
    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        src_d   = src_q;
        dst_d   = dst_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end else if (mv_req) begin
                    state_d = MV_RD;
                    src_d   = mv_src;
                    dst_d   = mv_dst;
                end else if (set) begin
                    wr_en   = 1'b1;
                    wr_idx  = wr_sel;
                    wr_data = in;
                end
            end
            MV_RD: begin
                tmp_d   = regs_q[src_q];
                state_d = MV_WR;
            end
            MV_WR: begin
                wr_en   = 1'b1;
                wr_idx  = dst_q;
                wr_data = tmp_q;
                state_d = IDLE;
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = idx_q;
                wr_data = '0;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // read data with bypass of a same-edge write to the selected register
    always_comb begin
        rd_data = regs_q[rd_sel];
        if (wr_en && (wr_idx == rd_sel)) begin
            rd_data = wr_data;
        end
    end

    // state, register file and registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            regs_q  <= '{default: '0};
            tmp_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            idx_q   <= idx_d;
            if (wr_en) begin
                regs_q[wr_idx] <= wr_data;
            end
            out_q   <= enable ? rd_data : '0;
            valid_q <= enable;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// tb_cpu_reg_bank: directed scenarios plus randomized traffic for
// cpu_reg_bank, checked against a behavioural model of the register file.
module tb_cpu_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default build: WIDTH=8, DEPTH=4
    logic       rst_n, set, enable, mv_req, clr_req;
    logic [7:0] din, dout;
    logic [1:0] wr_sel, rd_sel, mv_src, mv_dst;
    logic       out_valid, busy;

    // wide build: WIDTH=16, DEPTH=8
    logic        p_rst_n, p_set, p_enable, p_mv_req, p_clr_req;
    logic [15:0] p_din, p_dout;
    logic [2:0]  p_wr_sel, p_rd_sel, p_mv_src, p_mv_dst;
    logic        p_out_valid, p_busy;

    cpu_reg_bank u0 (
        .clk(clk), .rst_n(rst_n), .in(din), .set(set), .wr_sel(wr_sel),
        .enable(enable), .rd_sel(rd_sel), .out(dout), .out_valid(out_valid),
        .mv_req(mv_req), .mv_src(mv_src), .mv_dst(mv_dst),
        .clr_req(clr_req), .busy(busy)
    );

    cpu_reg_bank #(.WIDTH(16), .DEPTH(8)) u1 (
        .clk(clk), .rst_n(p_rst_n), .in(p_din), .set(p_set), .wr_sel(p_wr_sel),
        .enable(p_enable), .rd_sel(p_rd_sel), .out(p_dout), .out_valid(p_out_valid),
        .mv_req(p_mv_req), .mv_src(p_mv_src), .mv_dst(p_mv_dst),
        .clr_req(p_clr_req), .busy(p_busy)
    );

    int vectors    = 0;
    int miscompares = 0;

    // behavioural model of u0: register contents, pending operation, read port
    logic [7:0] m_reg [4];
    logic [7:0] m_out;
    logic       m_valid;
    int         m_busy_left = 0;
    logic       m_clearing  = 1'b0;
    logic [7:0] m_mv_val;
    int         m_mv_dst;

    // advance the model by one clock edge using the inputs currently applied
    function automatic void model_step();
        logic       we;
        int         wi;
        logic [7:0] wv;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
            m_out       = 8'h00;
            m_valid     = 1'b0;
            m_busy_left = 0;
            return;
        end
        we = 1'b0;
        wi = 0;
        wv = 8'h00;
        if (m_busy_left == 0) begin
            if (clr_req) begin
                m_clearing  = 1'b1;
                m_busy_left = 4;
            end else if (mv_req) begin
                m_clearing  = 1'b0;
                m_busy_left = 2;
                m_mv_val    = m_reg[mv_src];
                m_mv_dst    = int'(mv_dst);
            end else if (set) begin
                we = 1'b1;
                wi = int'(wr_sel);
                wv = din;
            end
        end else begin
            if (m_clearing) begin
                we = 1'b1;
                wi = 4 - m_busy_left;
                wv = 8'h00;
            end else if (m_busy_left == 1) begin
                we = 1'b1;
                wi = m_mv_dst;
                wv = m_mv_val;
            end
            m_busy_left--;
        end
        if (enable) begin
            m_out   = (we && wi == int'(rd_sel)) ? wv : m_reg[rd_sel];
            m_valid = 1'b1;
        end else begin
            m_out   = 8'h00;
            m_valid = 1'b0;
        end
        if (we) m_reg[wi] = wv;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; set = 1'b0; enable = 1'b0; mv_req = 1'b0; clr_req = 1'b0;
        din = 8'h00; wr_sel = 2'd0; rd_sel = 2'd0; mv_src = 2'd0; mv_dst = 2'd0;
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [7:0] val);
        set = 1'b1; wr_sel = idx; din = val;
        tick();
        set = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; set = 1'b1; din = 8'h77; enable = 1'b1; mv_req = 1'b1; clr_req = 1'b1;
        tick();
        tick();
        vectors++;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_out: got %h expected 00", dout); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        idle_inputs();
        // first edge out of reset already accepts a write (read bypass shows it)
        set = 1'b1; wr_sel = 2'd0; din = 8'h11; enable = 1'b1; rd_sel = 2'd0;
        tick();
        vectors++;
        if (dout !== 8'h11 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL first_write: got %h/%b expected 11/1", dout, out_valid);
        end
        set = 1'b0;
        for (int i = 1; i < 4; i++) begin
            rd_sel = 2'(i);
            tick();
            vectors++;
            if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d: got %h expected 00", i, dout); end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        write_reg(2'd2, 8'hAA);
        enable = 1'b1; rd_sel = 2'd2;
        tick();
        vectors++;
        if (dout !== 8'hAA || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL write_read: got %h/%b expected aa/1", dout, out_valid);
        end
        enable = 1'b0;
        tick();
        vectors++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL read_disabled: got %h/%b expected 00/0", dout, out_valid);
        end
    endtask

    task automatic test_bypass();
        set = 1'b1; wr_sel = 2'd1; din = 8'h55; enable = 1'b1; rd_sel = 2'd1;
        tick();
        vectors++;
        if (dout !== 8'h55) begin miscompares++; $display("FAIL bypass: got %h expected 55", dout); end
        idle_inputs();
    endtask

    task automatic test_move();
        logic [7:0] exp_rd [4];
        int n;
        write_reg(2'd0, 8'h34);
        // move accepted; a set on the same edge must be dropped
        mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd3;
        set = 1'b1; wr_sel = 2'd2; din = 8'h99;
        tick();
        mv_req = 1'b0;
        wr_sel = 2'd1; din = 8'hEE;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; tick(); end
        set = 1'b0;
        vectors++;
        if (n != 2) begin miscompares++; $display("FAIL move_busy: got %0d cycles expected 2", n); end
        exp_rd = '{8'h34, 8'h55, 8'hAA, 8'h34};
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            tick();
            vectors++;
            if (dout !== exp_rd[i]) begin
                miscompares++; $display("FAIL move_reg%0d: got %h expected %h", i, dout, exp_rd[i]);
            end
        end
        enable = 1'b0;
        // self-move keeps the value and still takes two busy cycles
        mv_req = 1'b1; mv_src = 2'd2; mv_dst = 2'd2;
        tick();
        mv_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; tick(); end
        vectors++;
        if (n != 2) begin miscompares++; $display("FAIL self_move_busy: got %0d cycles expected 2", n); end
        enable = 1'b1; rd_sel = 2'd2;
        tick();
        vectors++;
        if (dout !== 8'hAA) begin miscompares++; $display("FAIL self_move_val: got %h expected aa", dout); end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(8'h81 + i));
        clr_req = 1'b1; mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd1;
        tick();
        // requests during the clear must neither act nor be queued
        set = 1'b1; wr_sel = 2'd3; din = 8'hC3;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; tick(); end
        idle_inputs();
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL clear_busy: got %0d cycles expected 4", n); end
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_no_queue: got %b expected 0", busy); end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            tick();
            vectors++;
            if (dout !== 8'h00) begin miscompares++; $display("FAIL clear_reg%0d: got %h expected 00", i, dout); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(8'h40 + i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midclr_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        set = 1'b1; wr_sel = 2'd3; din = 8'h5A; enable = 1'b1; rd_sel = 2'd3;
        tick();
        vectors++;
        if (dout !== 8'h5A || busy !== 1'b0) begin
            miscompares++; $display("FAIL midclr_write: got %h/%b expected 5a/0", dout, busy);
        end
        set = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_sel = 2'(i);
            tick();
            vectors++;
            if (dout !== 8'h00) begin miscompares++; $display("FAIL midclr_reg%0d: got %h expected 00", i, dout); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            clr_req = ($urandom_range(0, 15) == 0);
            mv_req  = ($urandom_range(0, 5) == 0);
            set     = $urandom_range(0, 1) != 0;
            enable  = $urandom_range(0, 1) != 0;
            din     = 8'($urandom);
            wr_sel  = 2'($urandom);
            rd_sel  = 2'($urandom);
            mv_src  = 2'($urandom);
            mv_dst  = 2'($urandom);
            tick();
            vectors++;
            if (dout !== m_out || out_valid !== m_valid || busy !== (m_busy_left != 0)) begin
                miscompares++;
                $display("FAIL random_c%0d: got out=%h v=%b busy=%b expected out=%h v=%b busy=%b",
                         c, dout, out_valid, busy, m_out, m_valid, m_busy_left != 0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_param_build();
        int n;
        p_rst_n = 1'b1;
        p_set = 1'b1; p_wr_sel = 3'd7; p_din = 16'hFFFF;
        tick();
        p_set = 1'b0;
        p_mv_req = 1'b1; p_mv_src = 3'd7; p_mv_dst = 3'd0;
        tick();
        p_mv_req = 1'b0;
        n = 0;
        while (p_busy === 1'b1 && n < 30) begin n++; tick(); end
        vectors++;
        if (n != 2) begin miscompares++; $display("FAIL wide_move_busy: got %0d cycles expected 2", n); end
        p_enable = 1'b1; p_rd_sel = 3'd0;
        tick();
        vectors++;
        if (p_dout !== 16'hFFFF) begin miscompares++; $display("FAIL wide_move_val: got %h expected ffff", p_dout); end
        p_enable = 1'b0;
        p_clr_req = 1'b1;
        tick();
        p_clr_req = 1'b0;
        n = 0;
        while (p_busy === 1'b1 && n < 30) begin n++; tick(); end
        vectors++;
        if (n != 8) begin miscompares++; $display("FAIL wide_clear_busy: got %0d cycles expected 8", n); end
        p_enable = 1'b1; p_rd_sel = 3'd7;
        tick();
        vectors++;
        if (p_dout !== 16'h0000) begin miscompares++; $display("FAIL wide_clear_reg7: got %h expected 0000", p_dout); end
        p_enable = 1'b0;
    endtask

    initial begin
        p_rst_n = 1'b0; p_set = 1'b0; p_enable = 1'b0; p_mv_req = 1'b0; p_clr_req = 1'b0;
        p_din = 16'h0000; p_wr_sel = 3'd0; p_rd_sel = 3'd0; p_mv_src = 3'd0; p_mv_dst = 3'd0;
        test_reset();
        test_write_read();
        test_bypass();
        test_move();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_param_build();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_reg_bank.md
CPU_REG_BANK -- requirements
Module: cpu_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the register data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of registers (power of two, >=2).
REQ-003 The block SHALL have derived localparam AW = clog2(DEPTH), the register index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in, input, WIDTH bits: write data.
REQ-007 The block SHALL have port set, input, 1 bit: write strobe; loads in into reg[wr_sel].
REQ-008 The block SHALL have port wr_sel, input, AW bits: write register index.
REQ-009 The block SHALL have port enable, input, 1 bit: read strobe; drives reg[rd_sel] onto out.
REQ-010 The block SHALL have port rd_sel, input, AW bits: read register index.
REQ-011 The block SHALL have port out, output, WIDTH bits: registered read data, zero when not enabled.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out holds enabled read data.
REQ-013 The block SHALL have port mv_req, input, 1 bit: request copy reg[mv_src] -> reg[mv_dst].
REQ-014 The block SHALL have ports mv_src and mv_dst, input, AW bits each: move source and destination indices.
REQ-015 The block SHALL have port clr_req, input, 1 bit: request sequential clear of all registers.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a move or clear is in progress.

Function
REQ-017 The block SHALL implement FSM states IDLE, MV_RD, MV_WR, CLEAR; busy = (state != IDLE), registered.
REQ-018 In IDLE, with clr_req=1, the block SHALL go to CLEAR with clear index 0; clr_req SHALL take priority over mv_req and set.
REQ-019 In IDLE, with clr_req=0 and mv_req=1, the block SHALL go to MV_RD and latch mv_src and mv_dst.
REQ-020 In MV_RD, the block SHALL capture reg[src] into a temp register and go to MV_WR.
REQ-021 In MV_WR, the block SHALL write temp into reg[dst] and return to IDLE; a move SHALL take exactly 2 busy cycles.
REQ-022 With mv_src == mv_dst, the move SHALL still take 2 busy cycles and leave the register value unchanged.
REQ-023 In CLEAR, the block SHALL write 0 to reg[idx] each cycle, idx 0..DEPTH-1, and return to IDLE after idx = DEPTH-1 (DEPTH busy cycles, no idx wrap past DEPTH-1).
REQ-024 In IDLE, with clr_req=0, mv_req=0 and set=1, the block SHALL load reg[wr_sel] <= in.
REQ-025 A set asserted in the same cycle a move or clear is accepted SHALL be ignored.
REQ-026 While busy=1, set, mv_req and clr_req SHALL be ignored, with no queuing.
REQ-027 Reads SHALL remain serviced in all states: each cycle, enable=1 -> out <= reg[rd_sel], out_valid <= 1; enable=0 -> out <= 0, out_valid <= 0 (1-cycle read latency).
REQ-028 Read bypass: when a register is written in the same cycle it is read (IDLE write, MV_WR or CLEAR), out SHALL take the newly written value.
REQ-029 Index inputs SHALL always be in range (AW bits); no out-of-range handling is required.

Reset
REQ-030 On a clk edge with rst_n=0, the block SHALL set all registers, temp, out and out_valid to 0, set busy to 0, state to IDLE and clear index to 0.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 Reset asserted mid-move or mid-clear SHALL abort the operation with no further writes.
REQ-033 The first operation SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-034 Basic write/read (WIDTH=8, DEPTH=4): set=1, wr_sel=2, in=AA; next cycle enable=1, rd_sel=2 -> out=AA, out_valid=1 one cycle later; enable=0 -> out=00, out_valid=0.
REQ-035 Bypass: set=1, wr_sel=1, in=55 with enable=1, rd_sel=1 in the same cycle -> out=55 next cycle.
REQ-036 Move: reg0=34, mv_req=1, src=0, dst=3 -> busy=1 for 2 cycles, reg3=34, reg0=34; a set during busy leaves its target unchanged.
REQ-037 Clear: all registers nonzero, clr_req=1 together with mv_req=1 -> clear wins, busy for 4 cycles, all registers read 00 afterwards.
REQ-038 Reset mid-clear: rst_n=0 at the second CLEAR cycle -> busy=0, all registers 00, IDLE; a following write is accepted immediately.
REQ-039 Parametrised build: WIDTH=16, DEPTH=8; write FFFF to reg7, move 7 -> 0 -> reg0 = FFFF; clear takes 8 busy cycles.
